// File: rtl/pad_ctrl_pkg.sv
// Shared definitions for the input-pad controller: register map and
// per-pad edge event type.
package pad_ctrl_pkg;

  localparam int unsigned PAD_BUS_W = 32;

  localparam logic [2:0] PAD_ADDR_DATA = 3'd0;
  localparam logic [2:0] PAD_ADDR_DEB  = 3'd1;
  localparam logic [2:0] PAD_ADDR_RISE = 3'd2;
  localparam logic [2:0] PAD_ADDR_FALL = 3'd3;
  localparam logic [2:0] PAD_ADDR_PEND = 3'd4;

  typedef struct packed {
    logic rise;
    logic fall;
  } pad_evt_t;

  function automatic logic is_write_to(input logic sel, input logic we,
                                       input logic [2:0] addr,
                                       input logic [2:0] target);
    return sel && we && (addr == target);
  endfunction

endpackage

// File: rtl/pad_debounce.sv
// One pad lane: two-flop synchronizer, debounce counter, accepted level
// and single-cycle rise/fall events at the acceptance edge.
module pad_debounce
  import pad_ctrl_pkg::*;
#(
  parameter int DEB_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad,
  input  logic [DEB_W-1:0] period,
  input  logic             clr,
  output logic             level,
  output pad_evt_t         evt
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [DEB_W-1:0] cnt;
  logic             accept;

  function automatic logic [DEB_W-1:0] sat_inc(input logic [DEB_W-1:0] v,
                                               input logic [DEB_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  // A counter clear (period rewrite) wins over acceptance so the new
  // period always governs the whole qualifying window.
  assign accept = !clr && (sync2 != stable) && (cnt == period);

  // Synchronizer stage, then debounce stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      if (clr || (sync2 == stable)) begin
        cnt <= '0;
      end else if (cnt == period) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= sat_inc(cnt, period);
      end
    end
  end

  assign level    = stable;
  assign evt.rise = accept && sync2;
  assign evt.fall = accept && !sync2;

endmodule

// File: rtl/pad_input_ctrl.sv
// Input-pad controller: per-pad debounce lanes, register bank, edge
// interrupt pending bits and a single-cycle bus interface.
module pad_input_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int               NB_PADS = 8,
  parameter int               DEB_W   = 16,
  parameter logic [DEB_W-1:0] DEB_RST = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_PADS-1:0] i_pad_in,
  input  logic               i_sel,
  input  logic               i_we,
  input  logic [2:0]         i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ready,
  output logic               o_irq
);

  logic [DEB_W-1:0]   period;
  logic [NB_PADS-1:0] rise_en;
  logic [NB_PADS-1:0] fall_en;
  logic [NB_PADS-1:0] pend;
  logic [NB_PADS-1:0] pend_nxt;
  logic [NB_PADS-1:0] level;
  logic [NB_PADS-1:0] rise_vec;
  logic [NB_PADS-1:0] fall_vec;
  logic [NB_PADS-1:0] w1c;
  logic [31:0]        rd_word;
  logic               deb_clr;
  logic               rd_acc;
  logic               wdata_unused;
  pad_evt_t           evt [NB_PADS];

  assign deb_clr      = is_write_to(i_sel, i_we, i_addr, PAD_ADDR_DEB);
  assign rd_acc       = i_sel && !i_we;
  assign wdata_unused = ^i_wdata;

  for (genvar g = 0; g < NB_PADS; g++) begin : g_pad
    pad_debounce #(
      .DEB_W (DEB_W)
    ) u_deb (
      .clk    (i_clk),
      .rst    (i_rst),
      .pad    (i_pad_in[g]),
      .period (period),
      .clr    (deb_clr),
      .level  (level[g]),
      .evt    (evt[g])
    );
  end

  always_comb begin
    rise_vec = '0;
    fall_vec = '0;
    for (int i = 0; i < NB_PADS; i++) begin
      rise_vec[i] = evt[i].rise;
      fall_vec[i] = evt[i].fall;
    end
  end

  // New events are OR'd in after the clear, so a set beats a same-cycle W1C.
  always_comb begin
    w1c = '0;
    if (is_write_to(i_sel, i_we, i_addr, PAD_ADDR_PEND)) begin
      w1c = i_wdata[NB_PADS-1:0];
    end
    pend_nxt = (pend & ~w1c) | (rise_vec & rise_en) | (fall_vec & fall_en);
  end

  always_comb begin
    rd_word = '0;
    case (i_addr)
      PAD_ADDR_DATA: rd_word[NB_PADS-1:0] = level;
      PAD_ADDR_DEB:  rd_word[DEB_W-1:0]   = period;
      PAD_ADDR_RISE: rd_word[NB_PADS-1:0] = rise_en;
      PAD_ADDR_FALL: rd_word[NB_PADS-1:0] = fall_en;
      PAD_ADDR_PEND: rd_word[NB_PADS-1:0] = pend;
      default:       rd_word = '0;
    endcase
  end

  // Register bank and bus response stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      period  <= DEB_RST;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
      o_irq   <= 1'b0;
      o_ready <= 1'b0;
      o_rdata <= '0;
    end else begin
      o_ready <= i_sel;
      o_rdata <= rd_acc ? rd_word : '0;
      pend    <= pend_nxt;
      o_irq   <= |pend_nxt;
      if (i_sel && i_we) begin
        case (i_addr)
          PAD_ADDR_DEB:  period  <= i_wdata[DEB_W-1:0];
          PAD_ADDR_RISE: rise_en <= i_wdata[NB_PADS-1:0];
          PAD_ADDR_FALL: fall_en <= i_wdata[NB_PADS-1:0];
          default:       ;
        endcase
      end
    end
  end

endmodule
